// File: rtl/can_receiver.sv
// CAN 2.0A/B bit-level frame receiver.
// Destuffs, decodes SOF..EOF, checks CRC-15, drives the ACK slot.
module can_receiver #(
  parameter logic [14:0] CRC_POLY  = 15'h4599,
  parameter int unsigned IDLE_BITS = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_point,
  input  logic        rx_bit,
  output logic [10:0] rx_id_std,
  output logic [17:0] rx_id_ext,
  output logic        rx_ide,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [7:0]  rx_data [0:7],
  output logic [7:0]  rx_data_byte,
  output logic        wr_rx_data_byte,
  output logic        rx_valid,
  output logic        rx_error,
  output logic [2:0]  rx_err_code,
  output logic        ack_drive,
  output logic        rx_busy
);

  typedef enum logic [3:0] {
    IDLE, ID_STD, RTR1, IDE, ID_EXT, RTR2, R1, R0,
    DLC, DATA, CRC, CRC_DELIM, ACK, ACK_DELIM, EOF, ERR_WAIT
  } state_t;

  state_t      state, state_d;
  logic [4:0]  cnt;
  logic [2:0]  run;
  logic        last;
  logic [14:0] crc, crc_rx, crc_nxt;
  logic [10:0] sh_id_std;
  logic [17:0] sh_id_ext;
  logic        sh_ide, sh_rtr;
  logic [3:0]  sh_dlc, dlc_d, nbytes, nb_d;
  logic [2:0]  byte_idx;
  logic [7:0]  shreg;
  logic        valid_pend;
  logic        dstf, stuff, err, last_byte;
  logic [2:0]  code;

  // next state, stuff detection and error classification
  always_comb begin
    state_d   = state;
    err       = 1'b0;
    code      = 3'b000;
    dstf      = (state >= ID_STD) && (state <= CRC_DELIM);
    stuff     = dstf && (run == 3'd5);
    crc_nxt   = {crc[13:0], 1'b0} ^
                ((rx_bit ^ crc[14]) ? CRC_POLY : 15'd0);
    dlc_d     = {sh_dlc[2:0], rx_bit};
    nb_d      = sh_rtr ? 4'd0 :
                ((dlc_d > 4'd8) ? 4'd8 : dlc_d);
    last_byte = (({1'b0, byte_idx} + 4'd1) == nbytes);
    if (sample_point) begin
      if (stuff) begin
        if (rx_bit == last) begin
          err  = 1'b1;
          code = 3'b001;
        end
      end else begin
        unique case (state)
          IDLE:      if (!rx_bit) state_d = ID_STD;
          ID_STD:    if (cnt == 5'd10) state_d = RTR1;
          RTR1:      state_d = IDE;
          IDE:       state_d = rx_bit ? ID_EXT : R0;
          ID_EXT:    if (cnt == 5'd17) state_d = RTR2;
          RTR2:      state_d = R1;
          R1:        state_d = R0;
          R0:        state_d = DLC;
          DLC:
            if (cnt == 5'd3)
              state_d = (nb_d == 4'd0) ? CRC : DATA;
          DATA:
            if (cnt == 5'd7 && last_byte) state_d = CRC;
          CRC:       if (cnt == 5'd14) state_d = CRC_DELIM;
          CRC_DELIM: begin
            if (!rx_bit) begin
              err  = 1'b1;
              code = 3'b010;
            end else if (crc_rx != crc) begin
              err  = 1'b1;
              code = 3'b011;
            end else begin
              state_d = ACK;
            end
          end
          ACK:       state_d = ACK_DELIM;
          ACK_DELIM: begin
            if (!rx_bit) begin
              err  = 1'b1;
              code = 3'b010;
            end else begin
              state_d = EOF;
            end
          end
          EOF: begin
            if (!rx_bit) begin
              err  = 1'b1;
              code = 3'b010;
            end else if (cnt == 5'd6) begin
              state_d = IDLE;
            end
          end
          ERR_WAIT:
            if (rx_bit && cnt == 5'(IDLE_BITS - 1))
              state_d = IDLE;
          default:   state_d = IDLE;
        endcase
      end
      if (err) state_d = ERR_WAIT;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // datapath: destuff run, CRC, field capture, output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; run <= '0; last <= 1'b1;
      crc <= '0; crc_rx <= '0;
      sh_id_std <= '0; sh_id_ext <= '0;
      sh_ide <= 1'b0; sh_rtr <= 1'b0; sh_dlc <= '0;
      nbytes <= '0; byte_idx <= '0; shreg <= '0;
      valid_pend <= 1'b0;
      rx_id_std <= '0; rx_id_ext <= '0;
      rx_ide <= 1'b0; rx_rtr <= 1'b0; rx_dlc <= '0;
      for (int i = 0; i < 8; i++) rx_data[i] <= '0;
      rx_data_byte <= '0; wr_rx_data_byte <= 1'b0;
      rx_valid <= 1'b0; rx_error <= 1'b0;
      rx_err_code <= '0; ack_drive <= 1'b0;
      rx_busy <= 1'b0;
    end else begin
      rx_error        <= 1'b0;
      wr_rx_data_byte <= 1'b0;
      valid_pend      <= 1'b0;
      rx_valid        <= valid_pend;
      rx_busy         <= (state_d != IDLE);
      if (sample_point) begin
        if (err) begin
          rx_error    <= 1'b1;
          rx_err_code <= code;
          ack_drive   <= 1'b0;
          cnt         <= '0;
        end else if (stuff) begin
          run  <= 3'd1;
          last <= rx_bit;
        end else begin
          if (state >= ID_STD && state <= CRC) begin
            run  <= (rx_bit == last) ? run + 3'd1 : 3'd1;
            last <= rx_bit;
          end
          if (state >= ID_STD && state <= DATA) crc <= crc_nxt;
          cnt <= (state_d == state) ? cnt + 5'd1 : 5'd0;
          unique case (state)
            IDLE: if (!rx_bit) begin
              run <= 3'd1; last <= 1'b0; crc <= '0;
              sh_id_std <= '0; sh_id_ext <= '0;
              sh_ide <= 1'b0; sh_rtr <= 1'b0; sh_dlc <= '0;
            end
            ID_STD: sh_id_std <= {sh_id_std[9:0], rx_bit};
            RTR1:   sh_rtr <= rx_bit;
            IDE:    sh_ide <= rx_bit;
            ID_EXT: sh_id_ext <= {sh_id_ext[16:0], rx_bit};
            RTR2:   sh_rtr <= rx_bit;
            DLC: begin
              sh_dlc <= dlc_d;
              if (cnt == 5'd3) begin
                nbytes   <= nb_d;
                byte_idx <= '0;
              end
            end
            DATA: begin
              shreg <= {shreg[6:0], rx_bit};
              if (cnt == 5'd7) begin
                rx_data[byte_idx] <= {shreg[6:0], rx_bit};
                rx_data_byte      <= {shreg[6:0], rx_bit};
                wr_rx_data_byte   <= 1'b1;
                byte_idx          <= byte_idx + 3'd1;
                cnt               <= '0;
              end
            end
            CRC:       crc_rx <= {crc_rx[13:0], rx_bit};
            CRC_DELIM: ack_drive <= 1'b1;
            ACK:       ack_drive <= 1'b0;
            EOF: if (cnt == 5'd6) begin
              rx_id_std  <= sh_id_std;
              rx_id_ext  <= sh_ide ? sh_id_ext : 18'd0;
              rx_ide     <= sh_ide;
              rx_rtr     <= sh_rtr;
              rx_dlc     <= sh_dlc;
              valid_pend <= 1'b1;
            end
            ERR_WAIT: if (!rx_bit) cnt <= '0;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_can_receiver.sv
// Directed bench for can_receiver.
// Frames are encoded (CRC, stuffing) by the bench itself.
module tb_can_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_point = 1'b0;
  logic        rx_bit = 1'b1;
  logic [10:0] rx_id_std;
  logic [17:0] rx_id_ext;
  logic        rx_ide, rx_rtr;
  logic [3:0]  rx_dlc;
  logic [7:0]  rx_data [0:7];
  logic [7:0]  rx_data_byte;
  logic        wr_rx_data_byte, rx_valid, rx_error;
  logic [2:0]  rx_err_code;
  logic        ack_drive, rx_busy;

  can_receiver dut (
    .clk(clk), .rst_n(rst_n),
    .sample_point(sample_point), .rx_bit(rx_bit),
    .rx_id_std(rx_id_std), .rx_id_ext(rx_id_ext),
    .rx_ide(rx_ide), .rx_rtr(rx_rtr), .rx_dlc(rx_dlc),
    .rx_data(rx_data), .rx_data_byte(rx_data_byte),
    .wr_rx_data_byte(wr_rx_data_byte),
    .rx_valid(rx_valid), .rx_error(rx_error),
    .rx_err_code(rx_err_code), .ack_drive(ack_drive),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] id;
    logic [17:0] eid;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    int          flip;
    logic        bad_delim;
    logic        exp_valid;
    logic [2:0]  exp_code;
    logic        exp_ack;
    int          exp_nwr;
  } vec_t;

  vec_t vt [8];
  vec_t good;
  bit   tx [$];
  logic [7:0] wr_q [$];
  int n_wr = 0, n_valid = 0, n_err = 0, n_ack = 0;
  int n_chk = 0, n_fail = 0;

  // pulse monitor, away from the active edge
  always @(negedge clk) begin
    if (wr_rx_data_byte) begin
      n_wr++;
      wr_q.push_back(rx_data_byte);
    end
    if (rx_valid)  n_valid++;
    if (rx_error)  n_err++;
    if (ack_drive) n_ack++;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    rx_bit = b;
    sample_point = 1'b1;
    @(negedge clk);
    sample_point = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic int nbytes_of(input vec_t v);
    if (v.rtr) return 0;
    return (v.dlc > 4'd8) ? 8 : int'(v.dlc);
  endfunction

  task automatic build(input vec_t v);
    bit raw [$];
    logic [14:0] c;
    logic [7:0]  by;
    bit nx, lst;
    int rn;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(v.id[i]);
    if (v.ide) begin
      raw.push_back(1'b1);
      raw.push_back(1'b1);
      for (int i = 17; i >= 0; i--) raw.push_back(v.eid[i]);
      raw.push_back(v.rtr);
      raw.push_back(1'b0);
      raw.push_back(1'b0);
    end else begin
      raw.push_back(v.rtr);
      raw.push_back(1'b0);
      raw.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) raw.push_back(v.dlc[i]);
    for (int k = 0; k < nbytes_of(v); k++) begin
      by = v.data[63-8*k -: 8];
      for (int i = 7; i >= 0; i--) raw.push_back(by[i]);
    end
    c = '0;
    foreach (raw[j]) begin
      nx = raw[j] ^ c[14];
      c = {c[13:0], 1'b0};
      if (nx) c = c ^ 15'h4599;
    end
    if (v.flip >= 0) c[v.flip] = ~c[v.flip];
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    tx.delete();
    rn = 0;
    lst = 1'b1;
    foreach (raw[j]) begin
      tx.push_back(raw[j]);
      if (raw[j] == lst) rn++;
      else begin
        rn = 1;
        lst = raw[j];
      end
      if (rn == 5) begin
        tx.push_back(~lst);
        lst = ~lst;
        rn = 1;
      end
    end
    tx.push_back(~v.bad_delim);
    tx.push_back(1'b0);
    for (int i = 0; i < 20; i++) tx.push_back(1'b1);
  endtask

  task automatic chk_fields(input string nm);
    chk({nm, " id_std"}, 64'(rx_id_std), 64'(good.id));
    chk({nm, " id_ext"}, 64'(rx_id_ext),
        good.ide ? 64'(good.eid) : 64'd0);
    chk({nm, " ide"}, 64'(rx_ide), 64'(good.ide));
    chk({nm, " rtr"}, 64'(rx_rtr), 64'(good.rtr));
    chk({nm, " dlc"}, 64'(rx_dlc), 64'(good.dlc));
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int b_wr, b_val, b_err, b_ack, b_q, got;
    logic [7:0] by;
    build(v);
    b_wr = n_wr; b_val = n_valid;
    b_err = n_err; b_ack = n_ack;
    b_q = wr_q.size();
    foreach (tx[i]) send_bit(tx[i]);
    chk({nm, " valid"}, 64'(n_valid - b_val), 64'(v.exp_valid));
    chk({nm, " error"}, 64'(n_err - b_err),
        64'(v.exp_code != 3'b000));
    if (v.exp_code != 3'b000)
      chk({nm, " code"}, 64'(rx_err_code), 64'(v.exp_code));
    chk({nm, " ack_clks"}, 64'(n_ack - b_ack),
        v.exp_ack ? 64'd4 : 64'd0);
    got = n_wr - b_wr;
    chk({nm, " nwr"}, 64'(got), 64'(v.exp_nwr));
    for (int k = 0; k < v.exp_nwr && k < got; k++) begin
      by = v.data[63-8*k -: 8];
      chk($sformatf("%s wr_byte%0d", nm, k),
          64'(wr_q[b_q+k]), 64'(by));
    end
    chk({nm, " busy_end"}, 64'(rx_busy), 64'd0);
    if (v.exp_valid) begin
      good = v;
      for (int k = 0; k < v.exp_nwr; k++) begin
        by = v.data[63-8*k -: 8];
        chk($sformatf("%s rx_data%0d", nm, k),
            64'(rx_data[k]), 64'(by));
      end
    end
    chk_fields(nm);
  endtask

  initial begin
    int b_err, b_val, b_wr;
    vt[0] = '{11'h123, 18'h0, 1'b0, 1'b0, 4'd2,
              64'hAA55_0000_0000_0000, -1, 1'b0,
              1'b1, 3'b000, 1'b1, 2};
    vt[1] = '{11'h7FF, 18'h3FFFF, 1'b1, 1'b1, 4'd4,
              64'h0, -1, 1'b0,
              1'b1, 3'b000, 1'b1, 0};
    vt[2] = '{11'h123, 18'h0, 1'b0, 1'b0, 4'd2,
              64'hAA55_0000_0000_0000, 3, 1'b0,
              1'b0, 3'b011, 1'b0, 2};
    vt[3] = '{11'h123, 18'h0, 1'b0, 1'b0, 4'd2,
              64'hAA55_0000_0000_0000, -1, 1'b1,
              1'b0, 3'b010, 1'b0, 2};
    vt[4] = '{11'h456, 18'h0, 1'b0, 1'b0, 4'd9,
              64'h0102_0304_0506_0708, -1, 1'b0,
              1'b1, 3'b000, 1'b1, 8};
    vt[5] = '{11'h000, 18'h0, 1'b0, 1'b0, 4'd0,
              64'h0, -1, 1'b0,
              1'b1, 3'b000, 1'b1, 0};
    vt[6] = '{11'h555, 18'h2AAAA, 1'b1, 1'b0, 4'd1,
              64'hF000_0000_0000_0000, -1, 1'b0,
              1'b1, 3'b000, 1'b1, 1};
    vt[7] = '{11'h3C1, 18'h0, 1'b0, 1'b1, 4'd3,
              64'h0, -1, 1'b0,
              1'b1, 3'b000, 1'b1, 0};
    good = '{default: 0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(rx_busy), 64'd0);
    chk("reset ack", 64'(ack_drive), 64'd0);
    chk("reset code", 64'(rx_err_code), 64'd0);
    chk("reset data0", 64'(rx_data[0]), 64'd0);
    chk_fields("reset");
    repeat (3) send_bit(1'b1);

    for (int i = 0; i < 8; i++)
      run_vec(vt[i], $sformatf("v%0d", i));

    // six dominant bits inside the base ID -> stuff error
    b_err = n_err;
    b_val = n_valid;
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (6) send_bit(1'b0);
    chk("t3 error", 64'(n_err - b_err), 64'd1);
    chk("t3 code", 64'(rx_err_code), 64'd1);
    chk("t3 busy", 64'(rx_busy), 64'd1);
    repeat (10) send_bit(1'b1);
    chk("t3 busy after 10", 64'(rx_busy), 64'd1);
    send_bit(1'b1);
    chk("t3 busy after 11", 64'(rx_busy), 64'd0);
    chk("t3 no valid", 64'(n_valid - b_val), 64'd0);

    // reset in data byte 1 aborts silently
    build(vt[0]);
    b_wr = n_wr;
    begin
      int j;
      j = 0;
      while (j < tx.size() && n_wr - b_wr < 1) begin
        send_bit(tx[j]);
        j++;
      end
      for (int k = 0; k < 3; k++) send_bit(tx[j+k]);
    end
    chk("t6 busy before", 64'(rx_busy), 64'd1);
    b_err = n_err;
    b_val = n_valid;
    b_wr = n_wr;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6 busy", 64'(rx_busy), 64'd0);
    chk("t6 id_std", 64'(rx_id_std), 64'd0);
    chk("t6 data0", 64'(rx_data[0]), 64'd0);
    chk("t6 dlc", 64'(rx_dlc), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) send_bit(1'b1);
    chk("t6 no pulses",
        64'((n_err - b_err) + (n_valid - b_val) + (n_wr - b_wr)),
        64'd0);
    good = '{default: 0};
    run_vec(vt[0], "t6 frame");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
